// File: rtl/rst_seq_ctrl.sv
// Reset sequencer for the SoC wrapper: gates SoC resets on PLL lock and releases
// transport, POR and system resets in order; services SYSRESETREQ and host POR requests.
module rst_seq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_STABLE = 64,
    parameter int unsigned POR_CYCLES  = 255,
    parameter int unsigned SYS_CYCLES  = 16
) (
    input  logic       hclk,
    input  logic       RESET,
    input  logic       hpll_locked,
    input  logic       tpll_locked,
    input  logic       sysresetreq,
    input  logic       host_rst_req,
    output logic       transport_rst_n,
    output logic       poreset_n,
    output logic       sysreset_n,
    output logic [1:0] rst_cause,
    output logic       rst_busy
);

    localparam int unsigned MAX_DLY = (POR_CYCLES > SYS_CYCLES) ? POR_CYCLES : SYS_CYCLES;
    localparam int unsigned SW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned DW = $clog2(MAX_DLY + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_STABLE);
    localparam logic [DW-1:0] POR_LOAD = DW'(POR_CYCLES - 1);
    localparam logic [DW-1:0] SYS_LOAD = DW'(SYS_CYCLES - 1);

    typedef enum logic [2:0] {
        StLock   = 3'd0,
        StPor    = 3'd1,
        StSys    = 3'd2,
        StRun    = 3'd3,
        StSysrst = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [SW-1:0]     stab_q, stab_d, stab_inc;
    logic [DW-1:0]     dly_q, dly_d;
    logic [1:0]        cause_q, cause_d;
    logic [SYNC_STAGES-1:0] hsync_q, tsync_q;
    logic              lock_ok;
    logic              trn_q, por_q, sys_q, busy_q;

    // Lock synchronizers run free, independent of RESET.
    always_ff @(posedge hclk) begin
        hsync_q <= {hsync_q[SYNC_STAGES-2:0], hpll_locked};
        tsync_q <= {tsync_q[SYNC_STAGES-2:0], tpll_locked};
    end

    assign lock_ok  = hsync_q[SYNC_STAGES-1] & tsync_q[SYNC_STAGES-1];
    assign stab_inc = (stab_q == STAB_MAX) ? STAB_MAX : stab_q + SW'(1);

    always_comb begin
        state_d = state_q;
        stab_d  = '0;
        dly_d   = dly_q;
        cause_d = cause_q;
        if (RESET) begin
            state_d = StLock;
            dly_d   = '0;
            cause_d = 2'b00;
        end else if (state_q != StLock && !lock_ok) begin
            state_d = StLock;
            dly_d   = '0;
            cause_d = 2'b01;
        end else if (host_rst_req && (state_q inside {StSys, StRun, StSysrst})) begin
            state_d = StPor;
            dly_d   = POR_LOAD;
            cause_d = 2'b11;
        end else begin
            case (state_q)
                StLock: begin
                    dly_d = '0;
                    if (lock_ok) begin
                        stab_d = stab_inc;
                        if (stab_inc == STAB_MAX) begin
                            state_d = StPor;
                            dly_d   = POR_LOAD;
                        end
                    end
                end
                StPor: begin
                    if (dly_q == '0) begin
                        state_d = StSys;
                        dly_d   = SYS_LOAD;
                    end else begin
                        dly_d = dly_q - DW'(1);
                    end
                end
                StSys: begin
                    if (dly_q == '0) begin
                        state_d = StRun;
                    end else begin
                        dly_d = dly_q - DW'(1);
                    end
                end
                StRun: begin
                    if (sysresetreq) begin
                        state_d = StSysrst;
                        dly_d   = SYS_LOAD;
                        cause_d = 2'b10;
                    end
                end
                StSysrst: begin
                    // A held request keeps reloading, stretching the system reset.
                    if (sysresetreq) begin
                        dly_d = SYS_LOAD;
                    end else if (dly_q == '0) begin
                        state_d = StRun;
                    end else begin
                        dly_d = dly_q - DW'(1);
                    end
                end
                default: begin
                    state_d = StLock;
                    dly_d   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge hclk) begin
        state_q <= state_d;
        stab_q  <= stab_d;
        dly_q   <= dly_d;
        cause_q <= cause_d;
        trn_q   <= (state_d != StLock);
        por_q   <= (state_d inside {StSys, StRun, StSysrst});
        sys_q   <= (state_d == StRun);
        busy_q  <= (state_d != StRun);
    end

    assign transport_rst_n = trn_q;
    assign poreset_n       = por_q;
    assign sysreset_n      = sys_q;
    assign rst_cause       = cause_q;
    assign rst_busy        = busy_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed sequences plus random stimulus, compared each cycle
// against a deadline-based behavioural model of the reset sequence.
module tb_rst_seq_ctrl;

    localparam int unsigned SYNC = 2;
    localparam int unsigned LS   = 4;
    localparam int unsigned PC   = 8;
    localparam int unsigned SC   = 3;

    localparam int PH_LOCK   = 0;
    localparam int PH_POR    = 1;
    localparam int PH_SYS    = 2;
    localparam int PH_RUN    = 3;
    localparam int PH_SYSRST = 4;

    logic       hclk = 1'b0;
    logic       RESET = 1'b1;
    logic       hpll_locked = 1'b1;
    logic       tpll_locked = 1'b1;
    logic       sysresetreq = 1'b0;
    logic       host_rst_req = 1'b0;
    logic       transport_rst_n, poreset_n, sysreset_n, rst_busy;
    logic [1:0] rst_cause;

    int checks = 0;
    int errors = 0;

    always #5 hclk = ~hclk;

    rst_seq_ctrl #(
        .SYNC_STAGES(SYNC),
        .LOCK_STABLE(LS),
        .POR_CYCLES (PC),
        .SYS_CYCLES (SC)
    ) dut (
        .hclk           (hclk),
        .RESET          (RESET),
        .hpll_locked    (hpll_locked),
        .tpll_locked    (tpll_locked),
        .sysresetreq    (sysresetreq),
        .host_rst_req   (host_rst_req),
        .transport_rst_n(transport_rst_n),
        .poreset_n      (poreset_n),
        .sysreset_n     (sysreset_n),
        .rst_cause      (rst_cause),
        .rst_busy       (rst_busy)
    );

    // Model: phase plus an absolute release deadline (edge number) for timed phases.
    int         m_ph = PH_LOCK;
    int         m_run = 0;
    int         m_until = 0;
    int         m_cyc = 0;
    logic [1:0] m_cause = 2'b00;
    bit         m_hist[$];

    task automatic model_edge();
        bit ok;
        m_cyc++;
        m_hist.push_front(bit'(hpll_locked & tpll_locked));
        ok = m_hist[SYNC];
        if (m_hist.size() > 16) void'(m_hist.pop_back());
        if (RESET) begin
            m_ph = PH_LOCK; m_run = 0; m_cause = 2'b00;
        end else if (m_ph != PH_LOCK && !ok) begin
            m_ph = PH_LOCK; m_run = 0; m_cause = 2'b01;
        end else if (host_rst_req && (m_ph == PH_SYS || m_ph == PH_RUN || m_ph == PH_SYSRST)) begin
            m_ph = PH_POR; m_until = m_cyc + PC; m_cause = 2'b11;
        end else begin
            case (m_ph)
                PH_LOCK: begin
                    m_run = ok ? m_run + 1 : 0;
                    if (m_run == LS) begin
                        m_ph = PH_POR; m_until = m_cyc + PC; m_run = 0;
                    end
                end
                PH_POR: if (m_cyc == m_until) begin m_ph = PH_SYS; m_until = m_cyc + SC; end
                PH_SYS: if (m_cyc == m_until) m_ph = PH_RUN;
                PH_RUN: if (sysresetreq) begin
                    m_ph = PH_SYSRST; m_until = m_cyc + SC; m_cause = 2'b10;
                end
                default: begin
                    if (sysresetreq) m_until = m_cyc + SC;
                    else if (m_cyc == m_until) m_ph = PH_RUN;
                end
            endcase
        end
    endtask

    task automatic check1(string tag, logic [1:0] act, logic [1:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s: got %0b want %0b (edge %0d)", tag, act, exp, m_cyc);
        end
    endtask

    task automatic check_int(string tag, int act, int exp);
        checks++;
        assert (act == exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic check_outputs();
        check1("transport_rst_n", transport_rst_n, (m_ph != PH_LOCK));
        check1("poreset_n", poreset_n,
               (m_ph == PH_SYS || m_ph == PH_RUN || m_ph == PH_SYSRST));
        check1("sysreset_n", sysreset_n, (m_ph == PH_RUN));
        check1("rst_busy", rst_busy, (m_ph != PH_RUN));
        check1("rst_cause", rst_cause, m_cause);
    endtask

    task automatic step();
        @(posedge hclk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic wait_ph(int ph, int budget);
        int k = 0;
        while (m_ph != ph && k < budget) begin
            step();
            k++;
        end
        check_int("wait_phase", m_ph, ph);
    endtask

    initial begin
        int e_trn, e_por, e_sys, lo, bad, d, dh, dt, hold;
        for (int i = 0; i < int'(SYNC); i++) m_hist.push_back(1'b1);

        // 1: power-up release sequence
        repeat (5) step();
        RESET = 1'b0;
        e_trn = 0; e_por = 0; e_sys = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e_trn == 0 && transport_rst_n === 1'b1) e_trn = e;
            if (e_por == 0 && poreset_n === 1'b1) e_por = e;
            if (e_sys == 0 && sysreset_n === 1'b1 && rst_busy === 1'b0) e_sys = e;
        end
        check_int("t1_transport_edge", e_trn, 4);
        check_int("t1_poreset_edge", e_por, 12);
        check_int("t1_sysreset_edge", e_sys, 15);
        check1("t1_cause", rst_cause, 2'b00);

        // 2: single-cycle SYSRESETREQ
        sysresetreq = 1'b1;
        step();
        sysresetreq = 1'b0;
        lo = 0; bad = 0;
        for (int k = 0; k < 40 && sysreset_n !== 1'b1; k++) begin
            lo++;
            if (poreset_n !== 1'b1 || transport_rst_n !== 1'b1) bad = 1;
            step();
        end
        check_int("t2_sys_low", lo, SC);
        check_int("t2_upper_hold", bad, 0);
        check1("t2_cause", rst_cause, 2'b10);

        // 3: held SYSRESETREQ stretches the reset to the last request plus SYS_CYCLES
        repeat (3) step();
        lo = 0;
        sysresetreq = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (sysreset_n === 1'b0) lo++;
        end
        sysresetreq = 1'b0;
        for (int k = 0; k < 40 && sysreset_n !== 1'b1; k++) begin
            step();
            if (sysreset_n === 1'b0) lo++;
        end
        check_int("t3_sys_low", lo, 9 + SC);

        // 4: HCLK PLL dip in run, then a second dip while re-qualifying lock
        repeat (2) step();
        hpll_locked = 1'b0;
        d = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            d++;
            if (d == 3) hpll_locked = 1'b1;
            if (transport_rst_n === 1'b0) break;
        end
        hpll_locked = 1'b1;
        check_int("t4_loss_delay", d, SYNC + 1);
        check1("t4_cause", rst_cause, 2'b01);
        check1("t4_por_low", poreset_n, 1'b0);
        for (int k = 0; k < 20 && !(m_ph == PH_LOCK && m_run == 1); k++) step();
        hpll_locked = 1'b0;
        step();
        hpll_locked = 1'b1;
        d = 0;
        for (int k = 0; k < 20 && transport_rst_n !== 1'b1; k++) begin
            step();
            d++;
        end
        check_int("t4_relock", d, SYNC + LS);

        // 5: host POR request while in the system-reset stretch
        wait_ph(PH_RUN, 100);
        sysresetreq = 1'b1;
        step();
        sysresetreq = 1'b0;
        host_rst_req = 1'b1;
        step();
        host_rst_req = 1'b0;
        lo = 0; bad = 0;
        for (int k = 0; k < 40 && poreset_n !== 1'b1; k++) begin
            lo++;
            if (transport_rst_n !== 1'b1) bad = 1;
            step();
        end
        check_int("t5_por_low", lo, PC);
        lo = 0;
        for (int k = 0; k < 40 && sysreset_n !== 1'b1; k++) begin
            lo++;
            if (transport_rst_n !== 1'b1) bad = 1;
            step();
        end
        check_int("t5_sys_low", lo, SC);
        check_int("t5_transport_hold", bad, 0);
        check1("t5_cause", rst_cause, 2'b11);

        // 6: RESET beats host request mid-POR; lock loss beats sysresetreq
        host_rst_req = 1'b1;
        step();
        host_rst_req = 1'b0;
        repeat (3) step();
        RESET = 1'b1;
        host_rst_req = 1'b1;
        step();
        RESET = 1'b0;
        host_rst_req = 1'b0;
        check1("t6_trn", transport_rst_n, 1'b0);
        check1("t6_por", poreset_n, 1'b0);
        check1("t6_sys", sysreset_n, 1'b0);
        check1("t6_cause", rst_cause, 2'b00);
        wait_ph(PH_RUN, 100);
        repeat (2) step();
        sysresetreq = 1'b1;
        tpll_locked = 1'b0;
        for (int k = 0; k < 10 && transport_rst_n !== 1'b0; k++) step();
        check1("t6_loss_cause", rst_cause, 2'b01);
        tpll_locked = 1'b1;
        sysresetreq = 1'b0;

        // Random traffic against the model
        dh = 0; dt = 0; hold = 0;
        for (int i = 0; i < 4000; i++) begin
            RESET = ($urandom_range(0, 399) == 0);
            if (dh > 0) dh--;
            else if ($urandom_range(0, 149) == 0) dh = $urandom_range(1, 6);
            if (dt > 0) dt--;
            else if ($urandom_range(0, 149) == 0) dt = $urandom_range(1, 6);
            hpll_locked = (dh == 0);
            tpll_locked = (dt == 0);
            host_rst_req = ($urandom_range(0, 49) == 0);
            if (hold > 0) begin
                hold--;
            end else begin
                sysresetreq = ($urandom_range(0, 19) == 0);
                if (sysresetreq) hold = $urandom_range(0, 10);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
